// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the MEM pipeline stage: datapath widths,
//   default data-memory depth and the stage state encoding.
package mem_stage_pkg;

    localparam int DATA_W        = 16;
    localparam int REG_IDX_W     = 3;
    localparam int DEPTH_DEFAULT = 256;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem
//   Word-addressed data RAM for the MEM stage. It has one synchronous
//   write port and one registered read port. The read data is captured
//   at the same edge that presents the read address. Contents are not
//   reset.
// Ports:
//   clock  - sole clock
//   we     - write enable; wdata is written to waddr at the rising edge
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index; mem[raddr] appears on rdata after the edge
//   rdata  - registered read data
module data_mem
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM pipeline stage. It takes EX results through a valid/ready
//   handshake and performs the load or store on the data RAM. It then
//   presents a writeback result through a second valid/ready handshake.
//   ALU-only ops and stores complete in one cycle. Loads take two cycles
//   and pass through LOAD_WAIT while the registered RAM read completes.
//   The following accesses set the sticky addr_fault flag:
//     - an out-of-range address on a memory op;
//     - a request with both mem_read and mem_write set.
//   An out-of-range load returns zero.
// Ports:
//   clock, reset_n           - clock; synchronous active-low reset
//   in_valid / in_ready      - input handshake (accept when both high)
//   alu_result, store_data   - ALU output / memory word address, store data
//   mem_read, mem_write      - load / store request
//   reg_write, dest_reg      - register-file write control
//   flush                    - discard the pending load and the held result
//   out_valid / out_ready    - writeback handshake
//   out_data, out_dest_reg   - writeback data and destination
//   out_reg_write            - writeback enable (forced low for stores)
//   addr_fault               - sticky illegal-access flag
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    store_data,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic                 reg_write,
    input  logic [REG_IDX_W-1:0] dest_reg,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [REG_IDX_W-1:0] out_dest_reg,
    output logic                 out_reg_write,
    output logic                 addr_fault
);

    localparam int AW = $clog2(DEPTH);
    // One extra bit so that DEPTH itself is representable in the compare.
    localparam logic [DATA_W:0] ADDR_LIMIT = (DATA_W+1)'(DEPTH);

    state_t state, state_next;

    logic accept;
    logic is_load;
    logic is_store;
    logic op_conflict;
    logic addr_legal;
    logic ram_we;
    logic fault_set;

    logic                 ld_legal;
    logic [REG_IDX_W-1:0] ld_dest;
    logic                 ld_reg_write;
    logic [DATA_W-1:0]    ram_rdata;

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        accept      = 1'b0;
        is_load     = 1'b0;
        is_store    = 1'b0;
        op_conflict = 1'b0;
        addr_legal  = 1'b0;
        ram_we      = 1'b0;
        fault_set   = 1'b0;

        in_ready    = reset_n && (state == IDLE) && !flush && (!out_valid || out_ready);
        accept      = in_valid && in_ready;

        // A request with both read and write set falls back to an ALU-only op.
        is_load     = mem_read && !mem_write;
        is_store    = mem_write && !mem_read;
        op_conflict = mem_read && mem_write;
        addr_legal  = {1'b0, alu_result} < ADDR_LIMIT;

        ram_we      = accept && is_store && addr_legal;
        fault_set   = accept && (op_conflict || ((is_load || is_store) && !addr_legal));

        case (state)
            IDLE: begin
                if (accept && is_load) begin
                    state_next = LOAD_WAIT;
                end
            end
            LOAD_WAIT: begin
                // The load completes or is abandoned by flush. Both return to IDLE.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load metadata is held across LOAD_WAIT. It needs no reset because it
    // is consumed only on the edge after a load has been accepted.
    always_ff @(posedge clock) begin
        if (accept && is_load) begin
            ld_legal     <= addr_legal;
            ld_dest      <= dest_reg;
            ld_reg_write <= reg_write;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_dest_reg  <= '0;
            out_reg_write <= 1'b0;
            addr_fault    <= 1'b0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (state == LOAD_WAIT) begin
                out_valid     <= 1'b1;
                out_data      <= ld_legal ? ram_rdata : '0;
                out_dest_reg  <= ld_dest;
                out_reg_write <= ld_reg_write;
            end else if (accept && !is_load) begin
                out_valid     <= 1'b1;
                out_data      <= alu_result;
                out_dest_reg  <= dest_reg;
                out_reg_write <= reg_write && !is_store;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (fault_set) begin
                addr_fault <= 1'b1;
            end
        end
    end

    data_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_data_mem (
        .clock (clock),
        .we    (ram_we),
        .waddr (alu_result[AW-1:0]),
        .wdata (store_data),
        .raddr (alu_result[AW-1:0]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage
//   Bench for mem_stage. A driver issues EX results and predicts each
//   writeback result from a plain word-array memory model at accept time.
//   The prediction is queued, and a monitor pops and compares it whenever
//   a result is consumed. Directed sequences cover reset, latency,
//   backpressure, flush and address faults. A randomized phase follows.
module tb_mem_stage;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  dest;
        logic        rw;
    } res_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic [15:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [2:0]  dest_reg;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_dest_reg;
    logic        out_reg_write;
    logic        addr_fault;

    res_t        exp_q[$];
    logic [15:0] model_mem [DEPTH];
    int unsigned written_q[$];
    bit          exp_fault;
    int          n_checks;
    int          n_fails;
    bit          rand_rdy;
    bit          rdy_force;

    mem_stage #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .store_data    (store_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .dest_reg      (dest_reg),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_dest_reg  (out_dest_reg),
        .out_reg_write (out_reg_write),
        .addr_fault    (addr_fault)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: a flat word array, with faults and results
    // derived directly from the operation type and address range.
    function automatic void model_accept(input logic [15:0] a, input logic [15:0] sd,
                                         input logic rd, input logic wr, input logic rw,
                                         input logic [2:0] dst);
        res_t r;
        bit   legal;
        legal  = int'(a) < DEPTH;
        r.data = a;
        r.dest = dst;
        r.rw   = rw;
        if (rd && wr) begin
            exp_fault = 1'b1;
        end else if (wr) begin
            r.rw = 1'b0;
            if (legal) begin
                model_mem[int'(a)] = sd;
                written_q.push_back(int'(a));
            end else begin
                exp_fault = 1'b1;
            end
        end else if (rd) begin
            if (legal) begin
                r.data = model_mem[int'(a)];
            end else begin
                r.data    = 16'h0000;
                exp_fault = 1'b1;
            end
        end
        exp_q.push_back(r);
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] sd,
                         input logic rd, input logic wr, input logic rw,
                         input logic [2:0] dst);
        bit done;
        done       = 1'b0;
        in_valid   = 1'b1;
        alu_result = a;
        store_data = sd;
        mem_read   = rd;
        mem_write  = wr;
        reg_write  = rw;
        dest_reg   = dst;
        for (int i = 0; i < 64 && !done; i++) begin
            #3;
            if (in_ready === 1'b1) begin
                model_accept(a, sd, rd, wr, rw, dst);
                done = 1'b1;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fails++;
            $display("FAIL issue_timeout: addr 0x%0h never accepted, expected accept within 64 cycles", a);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"},     out_valid,     0);
        check({tag, "_out_data"},      out_data,      0);
        check({tag, "_out_dest_reg"},  out_dest_reg,  0);
        check({tag, "_out_reg_write"}, out_reg_write, 0);
        check({tag, "_addr_fault"},    addr_fault,    0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #3;
        check("in_ready_in_reset", in_ready, 0);
        @(negedge clock);
        #1;
        check_outputs_zero("reset");
        exp_q.delete();
        exp_fault = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Writeback-side ready: random backpressure or a forced level.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clock);
            #2;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: compares every consumed result against the queued prediction.
    initial begin
        res_t e;
        forever begin
            @(negedge clock);
            #4;
            if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_output: got data 0x%0h, expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out_data",      out_data,      e.data);
                    check("sb_out_dest_reg",  out_dest_reg,  e.dest);
                    check("sb_out_reg_write", out_reg_write, e.rw);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] sd;
        logic        rd;
        logic        wr;
        int unsigned kind;

        reset_n    = 1'b0;
        in_valid   = 1'b0;
        alu_result = '0;
        store_data = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        dest_reg   = '0;
        flush      = 1'b0;
        rand_rdy   = 1'b0;
        rdy_force  = 1'b1;
        exp_fault  = 1'b0;
        n_checks   = 0;
        n_fails    = 0;

        @(negedge clock);
        do_reset();

        // ALU op, latency 1
        issue(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5);
        #1;
        check("alu_out_valid", out_valid,    1);
        check("alu_out_data",  out_data,     16'h1234);
        check("alu_out_dest",  out_dest_reg, 5);
        check("alu_out_rw",    out_reg_write, 1);
        @(negedge clock);

        // Store then back-to-back load of the same word, latency 2
        issue(16'h0010, 16'hBEEF, 1'b0, 1'b1, 1'b1, 3'd1);
        issue(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2);
        #1;
        check("load_wait_out_valid", out_valid, 0);
        #2;
        check("load_wait_in_ready", in_ready, 0);
        @(negedge clock);
        #1;
        check("load_lat2_out_valid", out_valid, 1);
        check("load_lat2_out_data",  out_data,  16'hBEEF);
        @(negedge clock);

        // Out-of-range store aliasing word 0 must not write; out-of-range load returns 0
        issue(16'h0000, 16'h5A5A, 1'b0, 1'b1, 1'b0, 3'd0);
        #1;
        check("legal_store_no_fault", addr_fault, 0);
        @(negedge clock);
        issue(16'h0100, 16'hDEAD, 1'b0, 1'b1, 1'b0, 3'd0);
        #1;
        check("illegal_store_fault", addr_fault, 1);
        @(negedge clock);
        issue(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3);
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd4);
        repeat (3) @(negedge clock);

        // Backpressure: result held stable for three cycles, then replaced
        rdy_force = 1'b0;
        issue(16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("hold_out_valid", out_valid,    1);
            check("hold_out_data",  out_data,     16'h00AA);
            check("hold_out_dest",  out_dest_reg, 6);
            #2;
            check("hold_in_ready",  in_ready,     0);
            @(negedge clock);
        end
        rdy_force = 1'b1;
        issue(16'h00BB, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd7);
        #1;
        check("replace_out_valid", out_valid, 1);
        check("replace_out_data",  out_data,  16'h00BB);
        @(negedge clock);
        #1;
        check("drop_out_valid", out_valid, 0);
        @(negedge clock);
        check("fault_persists", addr_fault, 1);

        // Flush during LOAD_WAIT drops the load; the stored word survives
        issue(16'h0020, 16'h7777, 1'b0, 1'b1, 1'b0, 3'd0);
        issue(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("flush_out_valid", out_valid, 0);
        #2;
        check("flush_in_ready_idle", in_ready, 1);
        @(negedge clock);
        #1;
        check("flush_no_late_out", out_valid, 0);
        @(negedge clock);
        issue(16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd2);
        repeat (3) @(negedge clock);

        // Reset during LOAD_WAIT: outputs cleared, RAM retained
        issue(16'h0030, 16'hC0DE, 1'b0, 1'b1, 1'b0, 3'd0);
        issue(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd5);
        reset_n = 1'b0;
        @(negedge clock);
        #1;
        check_outputs_zero("midload_reset");
        #2;
        check("midload_reset_in_ready", in_ready, 0);
        exp_q.delete();
        exp_fault = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post_reset_no_out", out_valid, 0);
        @(negedge clock);
        issue(16'h0030, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd5);
        repeat (3) @(negedge clock);

        // Read+write conflict: ALU-only behaviour, fault, no RAM write
        issue(16'h0040, 16'h1111, 1'b0, 1'b1, 1'b0, 3'd0);
        #1;
        check("pre_conflict_no_fault", addr_fault, 0);
        @(negedge clock);
        issue(16'h0040, 16'h2222, 1'b1, 1'b1, 1'b1, 3'd2);
        #1;
        check("conflict_fault", addr_fault, 1);
        check("conflict_out_data", out_data, 16'h0040);
        @(negedge clock);
        issue(16'h0040, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3);

        // Randomized traffic with random writeback backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            a    = 16'($urandom_range(0, DEPTH - 1));
            sd   = 16'($urandom);
            rd   = 1'b0;
            wr   = 1'b0;
            if (kind <= 2) begin
                a = 16'($urandom);
            end else if (kind <= 5) begin
                wr = 1'b1;
            end else if (kind <= 7) begin
                if (written_q.size() > 0) begin
                    a  = 16'(written_q[$urandom_range(0, written_q.size() - 1)]);
                    rd = 1'b1;
                end
            end else if (kind == 8) begin
                a  = 16'($urandom_range(DEPTH, 16'hFFFF));
                rd = $urandom_range(0, 1) != 0;
                wr = !rd;
            end else begin
                rd = 1'b1;
                wr = 1'b1;
            end
            issue(a, sd, rd, wr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 1)) @(negedge clock);
        end

        rand_rdy  = 1'b0;
        rdy_force = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        #1;
        check("final_out_valid", out_valid, 0);
        check("final_addr_fault", addr_fault, exp_fault);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: DEPTH, default 256, number of 16-bit data-memory words (power of two).
REQ-002 Port: clock  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset_n  in  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  in  1  EX-stage result present.
REQ-005 Port: in_ready  out  1  stage can accept this cycle.
REQ-006 Port: alu_result  in  16  ALU output; memory word address for load/store.
REQ-007 Port: store_data  in  16  register operand written on store.
REQ-008 Port: mem_read  in  1  load request.
REQ-009 Port: mem_write  in  1  store request.
REQ-010 Port: reg_write  in  1  instruction writes the register file.
REQ-011 Port: dest_reg  in  3  destination register index.
REQ-012 Port: flush  in  1  discard in-flight and pending results.
REQ-013 Port: out_valid  out  1  writeback data present.
REQ-014 Port: out_ready  in  1  writeback consumes out_* this cycle.
REQ-015 Port: out_data  out  16  load data or passed ALU result.
REQ-016 Port: out_dest_reg  out  3  registered dest_reg.
REQ-017 Port: out_reg_write  out  1  registered reg_write, forced 0 for stores.
REQ-018 Port: addr_fault  out  1  sticky illegal-access flag.

Function
REQ-019 States SHALL be IDLE and LOAD_WAIT only.
REQ-020 in_ready SHALL be 1 iff state==IDLE, flush==0, and (out_valid==0 or out_ready==1).
REQ-021 Accept SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-022 An address is legal iff alu_result < DEPTH; RAM index = alu_result[log2(DEPTH)-1:0].
REQ-023 ALU-only op (mem_read=0, mem_write=0): out_valid=1 on the edge after accept; out_data=alu_result; latency 1.
REQ-024 Store (mem_write=1, mem_read=0, legal): RAM written at the accept edge; out_valid=1 after that edge with out_data=alu_result, out_reg_write=0; latency 1.
REQ-025 Load (mem_read=1, mem_write=0, legal): accept -> LOAD_WAIT; the next edge returns to IDLE with out_valid=1 and out_data=RAM word; latency 2.
REQ-026 A load SHALL return data from a store accepted on any earlier edge, including the immediately preceding one.
REQ-027 Illegal address with a memory op: addr_fault set, store suppressed, load returns 0x0000 at normal latency.
REQ-028 mem_read=1 with mem_write=1: addr_fault set, no RAM write, treated as ALU-only op.
REQ-029 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 out_valid SHALL clear on an out_ready edge unless a new result loads on the same edge; back-to-back ALU ops sustain one result per cycle.
REQ-031 flush=1 SHALL, at that edge, clear out_valid, abandon LOAD_WAIT (-> IDLE), and accept nothing; stores committed on earlier edges remain.
REQ-032 addr_fault SHALL be cleared only by reset.

Reset
REQ-033 reset_n=0 at a rising edge SHALL set state=IDLE, out_valid=0, out_data=0, out_dest_reg=0, out_reg_write=0, addr_fault=0.
REQ-034 Reset mid-load SHALL drop the load with no output; RAM contents SHALL NOT be reset.
REQ-035 in_ready SHALL be 0 while reset_n=0.

Structure
REQ-036 A shared package SHALL hold the state encoding, DATA_W=16, REG_IDX_W=3, and the DEPTH default.
REQ-037 The RAM SHALL be a sub-module data_mem: one synchronous write port and one registered read port, no reset.

Verification
REQ-038 Reset, then ALU op alu_result=0x1234, dest_reg=5, reg_write=1 -> next cycle out_valid=1, out_data=0x1234, out_dest_reg=5.
REQ-039 Store 0xBEEF at address 0x0010, next cycle load 0x0010 -> out_data=0xBEEF two cycles after the load accept; in_ready=0 during LOAD_WAIT.
REQ-040 Store to 0x0100 with DEPTH=256 -> addr_fault=1, RAM unchanged; load 0x0100 -> out_data=0x0000; fault persists until reset.
REQ-041 out_ready held 0 for 3 cycles with result 0x00AA -> out_* stable, in_ready=0; out_ready=1 -> out_valid drops or is replaced by the next result.
REQ-042 Load accepted, flush=1 on the following edge -> no out_valid; a later load of the same address returns the prior stored value.
REQ-043 reset_n=0 during LOAD_WAIT -> all outputs 0 next edge; RAM data written before reset still readable afterwards.
